// File: rtl/triangle_rasterizer_if.sv
// Bundles the vertex/colour request and the pixel-stream handshake of the triangle rasterizer.
interface triangle_rasterizer_if;
  logic        triangle_start;
  logic [10:0] v0_x;
  logic [10:0] v0_y;
  logic [10:0] v1_x;
  logic [10:0] v1_y;
  logic [10:0] v2_x;
  logic [10:0] v2_y;
  logic [7:0]  color;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [10:0] width;
  logic [10:0] height;
  logic        busy;
  logic        done;

  modport master (
    output triangle_start, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color, pixel_ready,
    input  pixel_x, pixel_y, pixel_data, pixel_valid, width, height, busy, done
  );

  modport slave (
    input  triangle_start, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y, color, pixel_ready,
    output pixel_x, pixel_y, pixel_data, pixel_valid, width, height, busy, done
  );
endinterface

// File: rtl/triangle_rasterizer.sv
// Edge-function triangle rasterizer: walks the bounding box row-major and offers one
// pixel per handshake, filled with the colour when inside the triangle (either winding).
module triangle_rasterizer (
  input  logic                 clk,
  input  logic                 rst,
  triangle_rasterizer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  function automatic logic [10:0] min3(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
    logic [10:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [10:0] max3(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
    logic [10:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic signed [12:0] diff13(input logic [10:0] p, input logic [10:0] q);
    return $signed({2'b00, p}) - $signed({2'b00, q});
  endfunction

  function automatic logic signed [24:0] cross25(input logic [10:0] ax, input logic [10:0] ay,
                                                 input logic [10:0] bx, input logic [10:0] by);
    logic [24:0] p;
    logic [24:0] q;
    p = {14'd0, ax} * {14'd0, by};
    q = {14'd0, bx} * {14'd0, ay};
    return $signed(p - q);
  endfunction

  function automatic logic signed [25:0] edge_eval(input logic signed [12:0] a, input logic signed [12:0] b,
                                                   input logic signed [24:0] c,
                                                   input logic [10:0] x, input logic [10:0] y);
    logic signed [25:0] aw, bw, cw, xw, yw;
    aw = {{13{a[12]}}, a};
    bw = {{13{b[12]}}, b};
    cw = {c[24], c};
    xw = $signed({15'd0, x});
    yw = $signed({15'd0, y});
    return aw * xw + bw * yw + cw;
  endfunction

  function automatic logic is_covered(input logic signed [25:0] e0, input logic signed [25:0] e1,
                                      input logic signed [25:0] e2);
    return ((e0 >= 26'sd0) && (e1 >= 26'sd0) && (e2 >= 26'sd0)) ||
           ((e0 <= 26'sd0) && (e1 <= 26'sd0) && (e2 <= 26'sd0));
  endfunction

  logic [2:0]  state_q, state_d;
  logic [10:0] v0x_q, v0y_q, v1x_q, v1y_q, v2x_q, v2y_q;
  logic [10:0] v0x_d, v0y_d, v1x_d, v1y_d, v2x_d, v2y_d;
  logic [7:0]  color_q, color_d;
  logic [10:0] min_x_q, min_y_q, max_x_q, max_y_q;
  logic [10:0] min_x_d, min_y_d, max_x_d, max_y_d;
  logic signed [12:0] a01_q, a12_q, a20_q, b01_q, b12_q, b20_q;
  logic signed [12:0] a01_d, a12_d, a20_d, b01_d, b12_d, b20_d;
  logic signed [24:0] c01_q, c12_q, c20_q, c01_d, c12_d, c20_d;
  logic signed [25:0] e01_q, e12_q, e20_q, e01_d, e12_d, e20_d;
  logic signed [25:0] r01_q, r12_q, r20_q, r01_d, r12_d, r20_d;
  logic [10:0] pixel_x_q, pixel_y_q, pixel_x_d, pixel_y_d;
  logic [7:0]  pixel_data_q, pixel_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [10:0] width_q, height_q, width_d, height_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic signed [25:0] a01_w, a12_w, a20_w, b01_w, b12_w, b20_w;
  logic signed [25:0] e01_init_s, e12_init_s, e20_init_s, area_s;

  assign a01_w = {{13{a01_q[12]}}, a01_q};
  assign a12_w = {{13{a12_q[12]}}, a12_q};
  assign a20_w = {{13{a20_q[12]}}, a20_q};
  assign b01_w = {{13{b01_q[12]}}, b01_q};
  assign b12_w = {{13{b12_q[12]}}, b12_q};
  assign b20_w = {{13{b20_q[12]}}, b20_q};

  assign e01_init_s = edge_eval(a01_q, b01_q, c01_q, min_x_q, min_y_q);
  assign e12_init_s = edge_eval(a12_q, b12_q, c12_q, min_x_q, min_y_q);
  assign e20_init_s = edge_eval(a20_q, b20_q, c20_q, min_x_q, min_y_q);
  assign area_s     = edge_eval(a01_q, b01_q, c01_q, v2x_q, v2y_q);

  // Next-state and datapath update for the rasterization sequence
  always_comb begin
    state_d = state_q;
    v0x_d = v0x_q; v0y_d = v0y_q; v1x_d = v1x_q; v1y_d = v1y_q; v2x_d = v2x_q; v2y_d = v2y_q;
    color_d = color_q;
    min_x_d = min_x_q; min_y_d = min_y_q; max_x_d = max_x_q; max_y_d = max_y_q;
    a01_d = a01_q; a12_d = a12_q; a20_d = a20_q;
    b01_d = b01_q; b12_d = b12_q; b20_d = b20_q;
    c01_d = c01_q; c12_d = c12_q; c20_d = c20_q;
    e01_d = e01_q; e12_d = e12_q; e20_d = e20_q;
    r01_d = r01_q; r12_d = r12_q; r20_d = r20_q;
    pixel_x_d = pixel_x_q; pixel_y_d = pixel_y_q;
    pixel_data_d = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    width_d = width_q; height_d = height_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.triangle_start) begin
          v0x_d = bus.v0_x; v0y_d = bus.v0_y;
          v1x_d = bus.v1_x; v1y_d = bus.v1_y;
          v2x_d = bus.v2_x; v2y_d = bus.v2_y;
          color_d = bus.color;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        min_x_d  = min3(v0x_q, v1x_q, v2x_q);
        min_y_d  = min3(v0y_q, v1y_q, v2y_q);
        max_x_d  = max3(v0x_q, v1x_q, v2x_q);
        max_y_d  = max3(v0y_q, v1y_q, v2y_q);
        width_d  = max_x_d - min_x_d;
        height_d = max_y_d - min_y_d;
        a01_d = diff13(v0y_q, v1y_q); b01_d = diff13(v1x_q, v0x_q);
        a12_d = diff13(v1y_q, v2y_q); b12_d = diff13(v2x_q, v1x_q);
        a20_d = diff13(v2y_q, v0y_q); b20_d = diff13(v0x_q, v2x_q);
        c01_d = cross25(v0x_q, v0y_q, v1x_q, v1y_q);
        c12_d = cross25(v1x_q, v1y_q, v2x_q, v2y_q);
        c20_d = cross25(v2x_q, v2y_q, v0x_q, v0y_q);
        state_d = S_INIT;
      end
      S_INIT: begin
        if (area_s == 26'sd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          e01_d = e01_init_s; e12_d = e12_init_s; e20_d = e20_init_s;
          r01_d = e01_init_s; r12_d = e12_init_s; r20_d = e20_init_s;
          pixel_x_d     = min_x_q;
          pixel_y_d     = min_y_q;
          pixel_data_d  = is_covered(e01_init_s, e12_init_s, e20_init_s) ? color_q : 8'h00;
          pixel_valid_d = 1'b1;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pixel_valid_q && bus.pixel_ready) begin
          if (pixel_x_q == max_x_q) begin
            if (pixel_y_q == max_y_q) begin
              pixel_valid_d = 1'b0;
              done_d        = 1'b1;
              busy_d        = 1'b0;
              state_d       = S_FINISH;
            end else begin
              // Row start E is kept apart so the row step never has to undo the x walk
              r01_d = r01_q + b01_w; r12_d = r12_q + b12_w; r20_d = r20_q + b20_w;
              e01_d = r01_d; e12_d = r12_d; e20_d = r20_d;
              pixel_x_d    = min_x_q;
              pixel_y_d    = pixel_y_q + 11'd1;
              pixel_data_d = is_covered(e01_d, e12_d, e20_d) ? color_q : 8'h00;
            end
          end else begin
            e01_d = e01_q + a01_w; e12_d = e12_q + a12_w; e20_d = e20_q + a20_w;
            pixel_x_d    = pixel_x_q + 11'd1;
            pixel_data_d = is_covered(e01_d, e12_d, e20_d) ? color_q : 8'h00;
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        pixel_valid_d = 1'b0;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      v0x_q <= 11'd0; v0y_q <= 11'd0; v1x_q <= 11'd0; v1y_q <= 11'd0; v2x_q <= 11'd0; v2y_q <= 11'd0;
      color_q <= 8'h00;
      min_x_q <= 11'd0; min_y_q <= 11'd0; max_x_q <= 11'd0; max_y_q <= 11'd0;
      a01_q <= 13'sd0; a12_q <= 13'sd0; a20_q <= 13'sd0;
      b01_q <= 13'sd0; b12_q <= 13'sd0; b20_q <= 13'sd0;
      c01_q <= 25'sd0; c12_q <= 25'sd0; c20_q <= 25'sd0;
      e01_q <= 26'sd0; e12_q <= 26'sd0; e20_q <= 26'sd0;
      r01_q <= 26'sd0; r12_q <= 26'sd0; r20_q <= 26'sd0;
      pixel_x_q <= 11'd0; pixel_y_q <= 11'd0;
      pixel_data_q <= 8'h00;
      pixel_valid_q <= 1'b0;
      width_q <= 11'd0; height_q <= 11'd0;
      busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v0x_q <= v0x_d; v0y_q <= v0y_d; v1x_q <= v1x_d; v1y_q <= v1y_d; v2x_q <= v2x_d; v2y_q <= v2y_d;
      color_q <= color_d;
      min_x_q <= min_x_d; min_y_q <= min_y_d; max_x_q <= max_x_d; max_y_q <= max_y_d;
      a01_q <= a01_d; a12_q <= a12_d; a20_q <= a20_d;
      b01_q <= b01_d; b12_q <= b12_d; b20_q <= b20_d;
      c01_q <= c01_d; c12_q <= c12_d; c20_q <= c20_d;
      e01_q <= e01_d; e12_q <= e12_d; e20_q <= e20_d;
      r01_q <= r01_d; r12_q <= r12_d; r20_q <= r20_d;
      pixel_x_q <= pixel_x_d; pixel_y_q <= pixel_y_d;
      pixel_data_q <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      width_q <= width_d; height_q <= height_d;
      busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.width       = width_q;
  assign bus.height      = height_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: reset, both windings, degenerate triangle,
// back-pressure, mid-scan reset and a stray start during scan.
module tb_triangle_rasterizer;

  logic clk = 1'b0;
  logic rst;
  triangle_rasterizer_if bus ();

  triangle_rasterizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int n_pix, n_cov, first_v, done_c, hold_err, stalls, order_err, busy_after, valid_after;
  int w_first, h_first;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: stray start pulsed mid-scan
  task automatic run_tri(input logic [10:0] ax, input logic [10:0] ay, input logic [10:0] bx,
                         input logic [10:0] by, input logic [10:0] cx, input logic [10:0] cy,
                         input logic [7:0] col, input int mode);
    int cyc;
    int k;
    bit held;
    bit rdy;
    logic [10:0] hx, hy;
    logic [7:0] hd;
    int ex, ey;
    logic [7:0] ed;
    n_pix = 0; n_cov = 0; first_v = -1; done_c = -1; hold_err = 0; stalls = 0; order_err = 0;
    w_first = -1; h_first = -1;
    k = 0; held = 1'b0;
    bus.v0_x = ax; bus.v0_y = ay; bus.v1_x = bx; bus.v1_y = by; bus.v2_x = cx; bus.v2_y = cy;
    bus.color = col;
    bus.pixel_ready = 1'b1;
    bus.triangle_start = 1'b1;
    tick();
    bus.triangle_start = 1'b0;
    cyc = 1;
    while (cyc < 150 && done_c < 0) begin
      tick();
      cyc++;
      if (held) begin
        if (bus.pixel_x !== hx || bus.pixel_y !== hy || bus.pixel_data !== hd) hold_err++;
        held = 1'b0;
      end
      if (bus.pixel_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          w_first = int'(bus.width);
          h_first = int'(bus.height);
        end
        rdy = (mode != 1) || (k % 4 == 0) || (k % 4 == 3);
        k++;
        bus.pixel_ready = rdy;
        if (rdy) begin
          ex = n_pix % 4;
          ey = n_pix / 4;
          ed = (ex + ey <= 3) ? 8'h5A : 8'h00;
          if (int'(bus.pixel_x) != ex || int'(bus.pixel_y) != ey || bus.pixel_data !== ed) order_err++;
          if (bus.pixel_data != 8'h00) n_cov++;
          n_pix++;
        end else begin
          held = 1'b1;
          hx = bus.pixel_x; hy = bus.pixel_y; hd = bus.pixel_data;
          stalls++;
        end
      end
      if (bus.done) done_c = cyc;
      if (mode == 2 && cyc == 8) begin
        bus.v0_x = 11'd5; bus.v0_y = 11'd5; bus.v1_x = 11'd5; bus.v1_y = 11'd5;
        bus.v2_x = 11'd5; bus.v2_y = 11'd5;
        bus.triangle_start = 1'b1;
      end else begin
        bus.triangle_start = 1'b0;
      end
    end
    tick();
    busy_after  = int'(bus.busy);
    valid_after = int'(bus.pixel_valid);
    bus.pixel_ready = 1'b1;
  endtask

  int seen_done, seen_valid, waited;

  initial begin
    rst = 1'b1;
    bus.triangle_start = 1'b0;
    bus.v0_x = 11'd0; bus.v0_y = 11'd0; bus.v1_x = 11'd0; bus.v1_y = 11'd0;
    bus.v2_x = 11'd0; bus.v2_y = 11'd0;
    bus.color = 8'h00;
    bus.pixel_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(bus.pixel_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_px", int'(bus.pixel_x), 0);
    check("rst_py", int'(bus.pixel_y), 0);
    check("rst_data", int'(bus.pixel_data), 0);
    check("rst_w", int'(bus.width), 0);
    check("rst_h", int'(bus.height), 0);
    rst = 1'b0;
    tick();

    run_tri(11'd0, 11'd0, 11'd3, 11'd0, 11'd0, 11'd3, 8'h5A, 0);
    check("base_first_valid", first_v, 3);
    check("base_width", w_first, 3);
    check("base_height", h_first, 3);
    check("base_pixels", n_pix, 16);
    check("base_covered", n_cov, 10);
    check("base_order", order_err, 0);
    check("base_done_cycle", done_c, 19);
    check("base_busy_after", busy_after, 0);
    check("base_valid_after", valid_after, 0);

    run_tri(11'd0, 11'd0, 11'd0, 11'd3, 11'd3, 11'd0, 8'h5A, 0);
    check("swap_pixels", n_pix, 16);
    check("swap_covered", n_cov, 10);
    check("swap_order", order_err, 0);
    check("swap_done_cycle", done_c, 19);

    run_tri(11'd5, 11'd5, 11'd5, 11'd5, 11'd5, 11'd5, 8'h77, 0);
    check("degen_no_valid", first_v, -1);
    check("degen_pixels", n_pix, 0);
    check("degen_done_cycle", done_c, 3);
    check("degen_busy_after", busy_after, 0);

    run_tri(11'd0, 11'd0, 11'd3, 11'd0, 11'd0, 11'd3, 8'h5A, 1);
    check("stall_pixels", n_pix, 16);
    check("stall_order", order_err, 0);
    check("stall_hold", hold_err, 0);
    check("stall_count", stalls, 16);
    check("stall_done_cycle", done_c, 35);

    // Reset while the 7th pixel (2,1) is on offer
    bus.v0_x = 11'd0; bus.v0_y = 11'd0; bus.v1_x = 11'd3; bus.v1_y = 11'd0;
    bus.v2_x = 11'd0; bus.v2_y = 11'd3; bus.color = 8'h5A;
    bus.pixel_ready = 1'b1;
    bus.triangle_start = 1'b1;
    tick();
    bus.triangle_start = 1'b0;
    waited = 0;
    while (waited < 40 && !(bus.pixel_valid && bus.pixel_x == 11'd2 && bus.pixel_y == 11'd1)) begin
      tick();
      waited++;
    end
    check("rst7_reached", int'(bus.pixel_valid && bus.pixel_x == 11'd2 && bus.pixel_y == 11'd1), 1);
    rst = 1'b1;
    #1;
    check("rst7_valid", int'(bus.pixel_valid), 0);
    check("rst7_busy", int'(bus.busy), 0);
    check("rst7_done", int'(bus.done), 0);
    tick();
    rst = 1'b0;
    seen_done = 0;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) seen_done++;
      if (bus.pixel_valid) seen_valid++;
    end
    check("rst7_no_done", seen_done, 0);
    check("rst7_no_valid", seen_valid, 0);

    run_tri(11'd0, 11'd0, 11'd3, 11'd0, 11'd0, 11'd3, 8'h5A, 0);
    check("restart_pixels", n_pix, 16);
    check("restart_order", order_err, 0);
    check("restart_done_cycle", done_c, 19);

    run_tri(11'd0, 11'd0, 11'd3, 11'd0, 11'd0, 11'd3, 8'h5A, 2);
    check("stray_pixels", n_pix, 16);
    check("stray_covered", n_cov, 10);
    check("stray_order", order_err, 0);
    check("stray_done_cycle", done_c, 19);
    check("stray_busy_after", busy_after, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
